// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, data width and baud-counter sizing helper for the UART transmitter.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam int DATA_BITS = 8;
   function automatic int baud_w(input int clks);
      return (clks < 2) ? 1 : $clog2(clks);
   endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with wrap-bit pointers; push refused when full, pop ignored when empty.
module uart_tx_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   logic [DW-1:0] mem [2**AW];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic push_ok, pop_ok;
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty   = wr_q == rd_q;
   assign level   = wr_q - rd_q;
   assign rdata   = mem[rd_q[AW-1:0]];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   always_comb begin
      wr_d = wr_q + (AW+1)'(push_ok);
      rd_d = rd_q + (AW+1)'(pop_ok);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_q[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: stream-fed 8N1 UART transmitter, LSB first, txd registered one cycle behind the FSM.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int FIFO_AW      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic             txd,
   output logic             busy,
   output logic [FIFO_AW:0] fifo_level
);
   localparam int BW = baud_w(CLKS_PER_BIT);
   localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d, rd_data;
   logic txd_q, txd_d, busy_q, busy_d;
   logic full, empty, tick, load, shift_now;
`ifdef UART_TX_PARITY_EN
   logic par_q, par_d;
`endif
   uart_tx_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_axis_tvalid),
      .wdata (s_axis_tdata),
      .pop   (load),
      .rdata (rd_data),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );
   assign s_axis_tready = !full;
   assign txd  = txd_q;
   assign busy = busy_q;
   // A pop from STOP chains straight into the next START with no idle bit.
   always_comb begin
      tick      = baud_q == '0;
      load      = !empty && (state_q == IDLE || (state_q == STOP && tick));
      shift_now = state_q == DATA && tick;
      state_d   = load ? START
                : (state_q == IDLE || !tick) ? state_q
                : state_q == START ? DATA
                : state_q == DATA ? ((bit_q == LAST_BIT) ? AFTER_DATA : DATA)
                : state_q == PARITY ? STOP
                : IDLE;
      baud_d    = (state_q == IDLE && !load) ? '0 : (load || tick) ? RELOAD : baud_q - BW'(1);
      shift_d   = load ? rd_data : shift_now ? shift_q >> 1 : shift_q;
      bit_d     = load ? '0 : shift_now ? bit_q + 3'd1 : bit_q;
      busy_d    = state_q != IDLE || fifo_level != '0;
`ifdef UART_TX_PARITY_EN
      par_d     = load ? ^rd_data : par_q;
      txd_d     = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
`else
      txd_d     = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed checks of frame timing, FIFO backpressure and reset for uart_tx_stream.
// Frame tables follow UART_TX_PARITY_EN so the same bench covers both builds.
module tb_uart_tx_stream;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] s_data = '0, s2_data = '0;
   logic s_valid = 1'b0, s2_valid = 1'b0;
   logic s_ready, txd, busy, s2_ready, txd2, busy2;
   logic [4:0] level, level2;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   uart_tx_stream #(.CLKS_PER_BIT(10), .FIFO_AW(4)) dut (
      .clk(clk), .rst(rst), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
      .s_axis_tready(s_ready), .txd(txd), .busy(busy), .fifo_level(level));
   uart_tx_stream #(.CLKS_PER_BIT(2), .FIFO_AW(4)) dut2 (
      .clk(clk), .rst(rst), .s_axis_tdata(s2_data), .s_axis_tvalid(s2_valid),
      .s_axis_tready(s2_ready), .txd(txd2), .busy(busy2), .fifo_level(level2));
   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;
   vec_t tbl [6];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic push1(input logic [7:0] b);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      @(posedge clk);
      #1 s_valid = 1'b0;
      s_data = 'x;
   endtask
   // Frame bit b of exp must hold for every one of its cpb cycles.
   task automatic check_frame(input bit sel, input int cpb, input logic [10:0] exp,
                              input bit wait_fall, input string nm);
      int bad;
      if (wait_fall) begin
         int k = 0;
         do begin
            @(negedge clk);
            k++;
         end while ((sel ? txd2 : txd) !== 1'b0 && k < 400);
         if (k >= 400) begin
            chk({nm, " start timeout"}, 1, 0);
            return;
         end
      end
      for (int b = 0; b < NB; b++) begin
         bad = 0;
         for (int c = 0; c < cpb; c++) begin
            if ((sel ? txd2 : txd) !== exp[b]) bad++;
            @(negedge clk);
         end
         chk($sformatf("%s bit%0d bad-cycles", nm, b), bad, 0);
      end
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      logic [7:0] b;
      logic [7:0] bytes [18];
      int idx, e18, refused;
`ifdef UART_TX_PARITY_EN
      tbl[0] = '{8'h55, 11'b1_0_01010101_0};
      tbl[1] = '{8'h00, 11'b1_0_00000000_0};
      tbl[2] = '{8'hFF, 11'b1_0_11111111_0};
      tbl[3] = '{8'hA5, 11'b1_0_10100101_0};
      tbl[4] = '{8'h07, 11'b1_1_00000111_0};
      tbl[5] = '{8'h03, 11'b1_0_00000011_0};
`else
      tbl[0] = '{8'h55, 11'b0_1_01010101_0};
      tbl[1] = '{8'h00, 11'b0_1_00000000_0};
      tbl[2] = '{8'hFF, 11'b0_1_11111111_0};
      tbl[3] = '{8'hA5, 11'b0_1_10100101_0};
      tbl[4] = '{8'h07, 11'b0_1_00000111_0};
      tbl[5] = '{8'h03, 11'b0_1_00000011_0};
`endif
      repeat (3) @(negedge clk);
      chk("reset txd", txd, 1);
      chk("reset tready", s_ready, 1);
      chk("reset busy", busy, 0);
      chk("reset level", level, 0);
      rst = 1'b0;
      s_data = 'x;
      repeat (4) @(negedge clk);
      chk("x-data idle level", level, 0);
      chk("x-data idle txd", txd, 1);
      push1(8'h55);
      @(negedge clk);
      chk("level after push", level, 1);
      chk("txd after N", txd, 1);
      @(negedge clk);
      chk("txd after N+1", txd, 1);
      chk("level after pop", level, 0);
      @(negedge clk);
      chk("txd falls after N+2", txd, 0);
      chk("busy in frame", busy, 1);
      check_frame(0, 10, tbl[0].frame, 0, "first 55");
      chk("busy after frame", busy, 0);
      chk("level after frame", level, 0);
      for (int i = 0; i < 6; i++) begin
         push1(tbl[i].data);
         check_frame(0, 10, tbl[i].frame, 1, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d busy end", i), busy, 0);
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 8'h41;
      @(posedge clk);
      #1 s_data = 8'h42;
      @(posedge clk);
      #1 s_valid = 1'b0;
      s_data = 'x;
`ifdef UART_TX_PARITY_EN
      check_frame(0, 10, 11'b1_0_01000001_0, 1, "A");
      check_frame(0, 10, 11'b1_0_01000010_0, 0, "B contiguous");
`else
      check_frame(0, 10, 11'b0_1_01000001_0, 1, "A");
      check_frame(0, 10, 11'b0_1_01000010_0, 0, "B contiguous");
`endif
      for (int i = 0; i < 18; i++) bytes[i] = 8'h30 + 8'(i);
      idx = 0;
      e18 = -1;
      refused = 0;
      @(negedge clk);
      fork
         begin
            for (int k = 0; k < 600 && idx < 18; k++) begin
               logic acc;
               s_valid = 1'b1;
               s_data = bytes[idx];
               acc = s_ready;
               if (!acc && !refused) begin
                  refused = 1;
                  chk("accepted before full", idx, 17);
                  chk("level when full", level, 16);
               end
               @(posedge clk);
               if (acc) begin
                  if (idx == 17) e18 = k;
                  idx++;
               end
               @(negedge clk);
            end
            s_valid = 1'b0;
            s_data = 'x;
            chk("18th push edge", e18, 2 + NB * 10);
         end
         begin
            for (int i = 0; i < 18; i++) begin
               b = bytes[i];
`ifdef UART_TX_PARITY_EN
               check_frame(0, 10, {1'b1, ^b, b, 1'b0}, i == 0, $sformatf("burst%0d", i));
`else
               check_frame(0, 10, {2'b01, b, 1'b0}, i == 0, $sformatf("burst%0d", i));
`endif
            end
         end
      join
      chk("burst busy end", busy, 0);
      push1(8'hA5);
      push1(8'h11);
      begin
         int k = 0;
         while (txd !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
         end
         chk("A5 start seen", k < 50, 1);
      end
      repeat (35) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid-reset txd", txd, 1);
      chk("mid-reset level", level, 0);
      chk("mid-reset busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset txd", txd, 1);
      push1(8'h3C);
`ifdef UART_TX_PARITY_EN
      check_frame(0, 10, 11'b1_0_00111100_0, 1, "3C after reset");
`else
      check_frame(0, 10, 11'b0_1_00111100_0, 1, "3C after reset");
`endif
      chk("3C level end", level, 0);
      @(negedge clk);
      s2_valid = 1'b1;
      s2_data = 8'hFF;
      @(posedge clk);
      #1 s2_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
      check_frame(1, 2, 11'b1_0_11111111_0, 1, "cpb2 FF");
`else
      check_frame(1, 2, 11'b0_1_11111111_0, 1, "cpb2 FF");
`endif
      chk("cpb2 busy end", busy2, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Byte-stream UART transmitter: accepts 8-bit bytes on a valid/ready stream interface, buffers them in a small FIFO and serialises them 8N1, LSB first, on txd.
- Driven by the CPU-side peripheral bus bridge or a DMA engine; txd drives the board's LED/serial pin.
- Its output is the line the simulation serial monitor decodes, so bit timing must be exact in clock cycles.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range 2..65535.
- FIFO_AW, 4, FIFO address width; FIFO depth = 2**FIFO_AW entries.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous assert, active-high.
- s_axis_tdata  input  8  byte to transmit.
- s_axis_tvalid  input  1  tdata valid.
- s_axis_tready  output  1  FIFO can accept; equals !fifo_full.
- txd  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (rst).
- Reset values: txd=1, s_axis_tready=1, busy=0, fifo_level=0, FSM=IDLE, counters=0, FIFO emptied.
- Push handshake: a byte is written when s_axis_tvalid && s_axis_tready at a rising edge. s_axis_tready is registered-derived from the full flag.
- Full FIFO: a push is refused even if a pop occurs in the same cycle; s_axis_tready rises on the cycle after the pop.
- Simultaneous push and pop on a non-full FIFO: both take effect; fifo_level unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
- IDLE: if FIFO non-empty, pop into the 8-bit shift register, load baud_cnt=CLKS_PER_BIT-1, go to START.
- START: txd=0.
- DATA: txd=shift[0]; after each bit, shift right and increment bit_cnt; leave after bit_cnt=7.
- STOP: txd=1. At end of STOP, if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit timing: each state lasts exactly CLKS_PER_BIT cycles. baud_cnt counts down to 0 and reloads on every bit boundary.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: byte accepted at edge N into an empty FIFO with the FSM idle → txd falls after edge N+2 (FIFO registered, IDLE pop).
- txd is driven from a flop (glitch-free).
- busy = (state!=IDLE) || (fifo_level!=0).
- Wrap-around: FIFO pointers are FIFO_AW+1 bits. full = MSBs differ and LSBs equal; empty = pointers equal. Pointers wrap naturally.
- Reset mid-frame: txd returns to 1 immediately (async) and the partially sent byte is discarded along with the FIFO contents. No truncated-frame recovery is attempted.
- s_axis_tdata is ignored when s_axis_tvalid=0; X on tdata with valid low must not propagate.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit is inserted between DATA and STOP in a PARITY state lasting CLKS_PER_BIT cycles. Parity is the XOR of the 8 data bits, computed at pop time. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: the PARITY state and parity logic are absent; 8N1 only.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), the constant DATA_BITS=8, and the baud-counter width function clog2(CLKS_PER_BIT).
- One natural sub-module: uart_tx_fifo, a synchronous FIFO parameterised by data width and FIFO_AW, providing push/pop/full/empty/level. The serialiser FSM stays in uart_tx_stream.

Test Plan:
- Single byte 0x55, CLKS_PER_BIT=10 → txd low for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10; busy falls 1 cycle after the stop bit ends; fifo_level returns to 0.
- Back-to-back push of 0x41 then 0x42 → two contiguous 100-cycle frames with no idle high between the stop bit and the next start bit; the monitor decodes "AB".
- tvalid held high with 18 distinct bytes, FIFO_AW=4 → 17 accepted (1 in shifter, 16 in FIFO), then tready=0. tready returns 1 the cycle after the second pop; all 18 bytes come out in order.
- Assert rst at cycle 35 of a frame carrying 0xA5 → txd=1 in the same cycle, fifo_level=0, busy=0; after release, pushing 0x3C yields a clean 0x3C frame.
- With UART_TX_PARITY_EN defined, byte 0x07 → parity bit 1, frame length 110 cycles; byte 0x03 → parity bit 0.
- CLKS_PER_BIT=2, push 0xFF → start bit 2 cycles low, then 18 cycles high; the baud-counter boundary has no off-by-one.
